// File: rtl/load_store_unit_pkg.sv
// Shared load/store type codes, FSM encodings and byte-lane helpers for the LSU.
package load_store_unit_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int LS_SEL_WIDTH   = 3;
  localparam int BUS_STRB_WIDTH = 4;

  typedef logic [LS_SEL_WIDTH:0] ls_type_t;

  localparam ls_type_t LS_TYPE_NONE = 4'd0;
  localparam ls_type_t LS_TYPE_LB   = 4'd1;
  localparam ls_type_t LS_TYPE_LH   = 4'd2;
  localparam ls_type_t LS_TYPE_LW   = 4'd3;
  localparam ls_type_t LS_TYPE_LBU  = 4'd4;
  localparam ls_type_t LS_TYPE_LHU  = 4'd5;
  localparam ls_type_t LS_TYPE_SB   = 4'd6;
  localparam ls_type_t LS_TYPE_SH   = 4'd7;
  localparam ls_type_t LS_TYPE_SW   = 4'd8;

  typedef enum logic [1:0] {
    LSU_STATE_IDLE = 2'd0,
    LSU_STATE_REQ  = 2'd1,
    LSU_STATE_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input ls_type_t t);
    return t inside {LS_TYPE_LB, LS_TYPE_LH, LS_TYPE_LW, LS_TYPE_LBU, LS_TYPE_LHU};
  endfunction

  function automatic logic is_store(input ls_type_t t);
    return t inside {LS_TYPE_SB, LS_TYPE_SH, LS_TYPE_SW};
  endfunction

  // Loads never assert strobes; unknown codes fall through to zero.
  function automatic logic [BUS_STRB_WIDTH-1:0] store_strb(input ls_type_t t, input logic [1:0] a);
    logic [BUS_STRB_WIDTH-1:0] s;
    case (t)
      LS_TYPE_SB: s = 4'b0001 << a;
      LS_TYPE_SH: s = a[1] ? 4'b1100 : 4'b0011;
      LS_TYPE_SW: s = 4'b1111;
      default:    s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_wdata(input ls_type_t t, input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] w;
    case (t)
      LS_TYPE_SB: w = {4{d[7:0]}};
      LS_TYPE_SH: w = {2{d[15:0]}};
      LS_TYPE_SW: w = d;
      default:    w = '0;
    endcase
    return w;
  endfunction

  function automatic logic is_misaligned(input ls_type_t t, input logic [1:0] a);
    logic half_acc;
    logic word_acc;
    half_acc = t inside {LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH};
    word_acc = t inside {LS_TYPE_LW, LS_TYPE_SW};
    return (half_acc && a[0]) || (word_acc && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational lane select and sign/zero extension of a read word.
module load_extend_unit
  import load_store_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_Rdata,
  input  logic [1:0]            i_Addr_Lo,
  input  ls_type_t              i_Load_Store_Type,
  output logic [DATA_WIDTH-1:0] o_Data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = i_Rdata[8*i_Addr_Lo +: 8];
    half_lane = i_Addr_Lo[1] ? i_Rdata[31:16] : i_Rdata[15:0];
    case (i_Load_Store_Type)
      LS_TYPE_LB:  o_Data = {{24{byte_lane[7]}}, byte_lane};
      LS_TYPE_LBU: o_Data = {24'd0, byte_lane};
      LS_TYPE_LH:  o_Data = {{16{half_lane[15]}}, half_lane};
      LS_TYPE_LHU: o_Data = {16'd0, half_lane};
      LS_TYPE_LW:  o_Data = i_Rdata;
      default:     o_Data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack bus transaction per accepted instruction.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag o_Misaligned.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Valid,
  input  logic [LS_SEL_WIDTH:0]     i_Load_Store_Type,
  input  logic [XLEN-1:0]           i_Addr,
  input  logic [XLEN-1:0]           i_Store_Data,
  output logic                      o_Stall,
  output logic                      o_Done,
  output logic                      o_Load_Valid,
  output logic [XLEN-1:0]           o_Load_Data,
  output logic                      o_Misaligned,
  output logic                      o_Bus_Req,
  output logic                      o_Bus_We,
  output logic [XLEN-1:0]           o_Bus_Addr,
  output logic [XLEN-1:0]           o_Bus_Wdata,
  output logic [BUS_STRB_WIDTH-1:0] o_Bus_Strb,
  input  logic                      i_Bus_Ack,
  input  logic [XLEN-1:0]           i_Bus_Rdata
);

  lsu_state_e                state_q, state_d;
  ls_type_t                  type_q, type_d;
  logic [1:0]                addr_lo_q, addr_lo_d;
  logic [XLEN-1:0]           bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]           bus_wdata_q, bus_wdata_d;
  logic [BUS_STRB_WIDTH-1:0] bus_strb_q, bus_strb_d;
  logic                      bus_we_q, bus_we_d;
  logic                      bus_req_q, bus_req_d;
  logic                      done_q, done_d;
  logic                      load_valid_q, load_valid_d;
  logic                      misaligned_q, misaligned_d;
  logic [XLEN-1:0]           load_data_q, load_data_d;
  logic [XLEN-1:0]           extended;
  logic                      accept;
  logic                      trap;

  load_extend_unit u_load_extend (
    .i_Rdata           (i_Bus_Rdata),
    .i_Addr_Lo         (addr_lo_q),
    .i_Load_Store_Type (type_q),
    .o_Data            (extended)
  );

  assign accept = (state_q == LSU_STATE_IDLE) && i_Valid &&
                  (is_load(i_Load_Store_Type) || is_store(i_Load_Store_Type));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(i_Load_Store_Type, i_Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    addr_lo_d    = addr_lo_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_strb_d   = bus_strb_q;
    bus_we_d     = bus_we_q;
    load_data_d  = load_data_q;
    bus_req_d    = 1'b0;
    done_d       = 1'b0;
    load_valid_d = 1'b0;
    misaligned_d = 1'b0;
    case (state_q)
      LSU_STATE_IDLE: begin
        if (accept) begin
          type_d = i_Load_Store_Type;
          if (trap) begin
            state_d      = LSU_STATE_DONE;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d     = LSU_STATE_REQ;
            bus_req_d   = 1'b1;
            addr_lo_d   = i_Addr[1:0];
            bus_addr_d  = {i_Addr[XLEN-1:2], 2'b00};
            bus_we_d    = is_store(i_Load_Store_Type);
            bus_strb_d  = store_strb(i_Load_Store_Type, i_Addr[1:0]);
            bus_wdata_d = store_wdata(i_Load_Store_Type, i_Store_Data);
          end
        end
      end
      LSU_STATE_REQ: begin
        bus_req_d = 1'b1;
        if (i_Bus_Ack) begin
          state_d      = LSU_STATE_DONE;
          bus_req_d    = 1'b0;
          done_d       = 1'b1;
          load_valid_d = is_load(type_q);
          if (is_load(type_q)) load_data_d = extended;
        end
      end
      default: state_d = LSU_STATE_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= LSU_STATE_IDLE;
      type_q       <= LS_TYPE_NONE;
      addr_lo_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_strb_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      done_q       <= 1'b0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      addr_lo_q    <= addr_lo_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_strb_q   <= bus_strb_d;
      bus_we_q     <= bus_we_d;
      bus_req_q    <= bus_req_d;
      done_q       <= done_d;
      load_valid_q <= load_valid_d;
      misaligned_q <= misaligned_d;
      load_data_q  <= load_data_d;
    end
  end

  // Stall covers the accepting IDLE cycle and all of REQ, so the pipeline moves on at the end of DONE.
  assign o_Stall      = !i_Reset && (accept || (state_q == LSU_STATE_REQ));
  assign o_Done       = done_q;
  assign o_Load_Valid = load_valid_q;
  assign o_Load_Data  = load_data_q;
  assign o_Misaligned = misaligned_q;
  assign o_Bus_Req    = bus_req_q;
  assign o_Bus_We     = bus_we_q;
  assign o_Bus_Addr   = bus_addr_q;
  assign o_Bus_Wdata  = bus_wdata_q;
  assign o_Bus_Strb   = bus_strb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand-written multi-cycle sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    ls_type_t    typ;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_bus_addr;
    logic [31:0] exp_wdata;
    logic        exp_lv;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        valid;
  ls_type_t    ls_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int compared;
  int mismatched;

  vec_t vecs[9];

  load_store_unit dut (
    .i_Clk             (clk),
    .i_Reset           (reset),
    .i_Valid           (valid),
    .i_Load_Store_Type (ls_type),
    .i_Addr            (addr),
    .i_Store_Data      (store_data),
    .o_Stall           (stall),
    .o_Done            (done),
    .o_Load_Valid      (load_valid),
    .o_Load_Data       (load_data),
    .o_Misaligned      (misaligned),
    .o_Bus_Req         (bus_req),
    .o_Bus_We          (bus_we),
    .o_Bus_Addr        (bus_addr),
    .o_Bus_Wdata       (bus_wdata),
    .o_Bus_Strb        (bus_strb),
    .i_Bus_Ack         (bus_ack),
    .i_Bus_Rdata       (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, "_req"},  {31'd0, bus_req},    32'd0);
    checkOutput({tag, "_done"}, {31'd0, done},       32'd0);
    checkOutput({tag, "_lv"},   {31'd0, load_valid}, 32'd0);
  endtask

  // Drives one transaction from acceptance through DONE and back to IDLE.
  task automatic applyStimulus(input vec_t v, input string tag);
    valid      = 1'b1;
    ls_type    = v.typ;
    addr       = v.addr;
    store_data = v.sdata;
    #1;
    checkOutput({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
    tick();
    valid   = 1'b0;
    ls_type = LS_TYPE_NONE;
    for (int k = 0; k <= v.delay; k++) begin
      checkOutput({tag, "_req"},      {31'd0, bus_req}, 32'd1);
      checkOutput({tag, "_we"},       {31'd0, bus_we},  {31'd0, v.exp_we});
      checkOutput({tag, "_strb"},     {28'd0, bus_strb}, {28'd0, v.exp_strb});
      checkOutput({tag, "_bus_addr"}, bus_addr,         v.exp_bus_addr);
      if (v.exp_we) checkOutput({tag, "_wdata"}, bus_wdata, v.exp_wdata);
      checkOutput({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
      checkOutput({tag, "_done_early"}, {31'd0, done}, 32'd0);
      if (k < v.delay) tick();
    end
    bus_ack   = 1'b1;
    bus_rdata = v.rdata;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    #1;
    checkOutput({tag, "_done"},       {31'd0, done},       32'd1);
    checkOutput({tag, "_lv"},         {31'd0, load_valid}, {31'd0, v.exp_lv});
    if (v.exp_lv) checkOutput({tag, "_data"}, load_data, v.exp_data);
    checkOutput({tag, "_req_done"},   {31'd0, bus_req},    32'd0);
    checkOutput({tag, "_stall_done"}, {31'd0, stall},      32'd0);
    checkOutput({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    tick();
    checkIdleQuiet({tag, "_after"});
  endtask

  initial begin
    vec_t mis;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    valid      = 1'b0;
    ls_type    = LS_TYPE_NONE;
    addr       = '0;
    store_data = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;

    //            typ          addr          sdata         rdata         dly we strb     busaddr       wdata         lv  data
    vecs[0] = '{LS_TYPE_LB,  32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 4'b0000, 32'h0000_1000, 32'h0,        1, 32'hFFFF_FF80};
    vecs[1] = '{LS_TYPE_LBU, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 4'b0000, 32'h0000_1000, 32'h0,        1, 32'h0000_0080};
    vecs[2] = '{LS_TYPE_SH,  32'h0000_2002, 32'h0000_BEEF, 32'h0,        0, 1, 4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 0, 32'h0};
    vecs[3] = '{LS_TYPE_SW,  32'h0000_4000, 32'hDEAD_BEEF, 32'h0,        3, 1, 4'b1111, 32'h0000_4000, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[4] = '{LS_TYPE_LH,  32'h0000_1002, 32'h0,        32'h80FF_1234, 0, 0, 4'b0000, 32'h0000_1000, 32'h0,        1, 32'hFFFF_80FF};
    vecs[5] = '{LS_TYPE_LHU, 32'h0000_1002, 32'h0,        32'h80FF_1234, 2, 0, 4'b0000, 32'h0000_1000, 32'h0,        1, 32'h0000_80FF};
    vecs[6] = '{LS_TYPE_LB,  32'h0000_1001, 32'h0,        32'h80FF_1234, 1, 0, 4'b0000, 32'h0000_1000, 32'h0,        1, 32'h0000_0012};
    vecs[7] = '{LS_TYPE_SB,  32'h0000_5001, 32'h1234_56A5, 32'h0,        0, 1, 4'b0010, 32'h0000_5000, 32'hA5A5_A5A5, 0, 32'h0};
    vecs[8] = '{LS_TYPE_LW,  32'h0000_6000, 32'h0,        32'hCAFE_F00D, 0, 0, 4'b0000, 32'h0000_6000, 32'h0,        1, 32'hCAFE_F00D};

    // Reset state: every output low while reset is held.
    tick();
    tick();
    checkIdleQuiet("reset");
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_addr",  bus_addr, 32'd0);
    checkOutput("reset_strb",  {28'd0, bus_strb}, 32'd0);
    checkOutput("reset_data",  load_data, 32'd0);
    checkOutput("reset_mis",   {31'd0, misaligned}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back LW then SW held valid through DONE: SW must wait for a fresh IDLE cycle.
    valid = 1'b1; ls_type = LS_TYPE_LW; addr = 32'h0000_7000; store_data = 32'h0;
    tick();
    checkOutput("b2b_lw_req", {31'd0, bus_req}, 32'd1);
    valid = 1'b1; ls_type = LS_TYPE_SW; addr = 32'h0000_7004; store_data = 32'h1357_9BDF;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    #1;
    checkOutput("b2b_lw_done",  {31'd0, done}, 32'd1);
    checkOutput("b2b_lw_data",  load_data, 32'h0BAD_F00D);
    checkOutput("b2b_done_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("b2b_gap_req",   {31'd0, bus_req}, 32'd0);
    checkOutput("b2b_gap_done",  {31'd0, done},    32'd0);
    checkOutput("b2b_gap_stall", {31'd0, stall},   32'd1);
    tick();
    valid = 1'b0; ls_type = LS_TYPE_NONE;
    checkOutput("b2b_sw_req",   {31'd0, bus_req}, 32'd1);
    checkOutput("b2b_sw_we",    {31'd0, bus_we},  32'd1);
    checkOutput("b2b_sw_addr",  bus_addr, 32'h0000_7004);
    checkOutput("b2b_sw_wdata", bus_wdata, 32'h1357_9BDF);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1;
    checkOutput("b2b_sw_done", {31'd0, done},       32'd1);
    checkOutput("b2b_sw_lv",   {31'd0, load_valid}, 32'd0);
    tick();

    // Reset during REQ, followed by a stray late ack in IDLE.
    valid = 1'b1; ls_type = LS_TYPE_LW; addr = 32'h0000_8000;
    tick();
    valid = 1'b0; ls_type = LS_TYPE_NONE;
    checkOutput("rst_req_before", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdleQuiet("rst_req_after");
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    checkIdleQuiet("rst_late_ack");
    checkOutput("rst_late_stall", {31'd0, stall}, 32'd0);
    tick();
    checkIdleQuiet("rst_late_ack2");

    // Unknown type code behaves as no instruction.
    valid = 1'b1; ls_type = 4'hF; addr = 32'h0000_9000;
    #1;
    checkOutput("unk_stall", {31'd0, stall}, 32'd0);
    tick();
    valid = 1'b0; ls_type = LS_TYPE_NONE;
    checkIdleQuiet("unk");
    tick();

    // Misaligned LW at 0x3001.
`ifdef LSU_MISALIGN_TRAP_EN
    valid = 1'b1; ls_type = LS_TYPE_LW; addr = 32'h0000_3001;
    tick();
    valid = 1'b0; ls_type = LS_TYPE_NONE;
    checkOutput("mis_req",  {31'd0, bus_req},    32'd0);
    checkOutput("mis_done", {31'd0, done},       32'd1);
    checkOutput("mis_flag", {31'd0, misaligned}, 32'd1);
    checkOutput("mis_lv",   {31'd0, load_valid}, 32'd0);
    tick();
    checkIdleQuiet("mis_after");
    checkOutput("mis_flag_after", {31'd0, misaligned}, 32'd0);
`else
    mis = '{LS_TYPE_LW, 32'h0000_3001, 32'h0, 32'h0123_4567, 0, 0, 4'b0000, 32'h0000_3000, 32'h0, 1, 32'h0123_4567};
    applyStimulus(mis, "mis_lw");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
